// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Round-robin arbiter that multiplexes NUM_PORTS requesters (core, servo
// control, IR decoder, VGA reader) onto one single-port memory with a fixed
// read latency. One access is issued per clock. Read data is returned to the
// port that issued the read, in issue order.
//
// Optional feature (compile-time macro MEM_ARB_PRIO_EN):
//   defined   - port 0 has strict priority. Ports 1..NUM_PORTS-1 share the
//               round-robin pointer, which moves only on grants to them.
//   undefined - pure round-robin over all ports.
//
// Parameters:
//   NUM_PORTS  number of requester ports (2..8)
//   ADDR_W     address width
//   DATA_W     data width
//   MEM_LAT    cycles from mem_en to mem_rdata valid (1..4)
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous, active-high reset
//   req        per-port request, held until acked
//   we         per-port write enable (1 = write, 0 = read)
//   addr       flattened per-port address, port i at [i*ADDR_W +: ADDR_W]
//   wdata      flattened per-port write data, port i at [i*DATA_W +: DATA_W]
//   ack        combinational one-hot grant (accepted at the closing edge)
//   rvalid     registered one-hot read-return strobe
//   rdata      registered read data shared by all ports, qualified by rvalid
//   mem_en     registered memory access strobe
//   mem_we     registered memory write enable
//   mem_addr   registered memory address
//   mem_wdata  registered memory write data
//   mem_rdata  memory read data, valid MEM_LAT cycles after mem_en
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int MEM_LAT   = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [NUM_PORTS-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int PTR_W = $clog2(NUM_PORTS);
  // One slot per cycle between the grant edge and the cycle in which
  // mem_rdata is valid for that read.
  localparam int DEPTH = MEM_LAT + 1;

`ifdef MEM_ARB_PRIO_EN
  // Port 0 is handled ahead of the rotating search.
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [PTR_W-1:0] id);
    logic [NUM_PORTS-1:0] v;
    for (int i = 0; i < NUM_PORTS; i++) begin
      v[i] = (id == PTR_W'(i));
    end
    return v;
  endfunction

  // Next search start after a grant to port id. Wrapping to 0 also works in
  // priority mode: the rotating search never looks at port 0, so a pointer
  // of 0 starts at port 1.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] id);
    return (id == PTR_W'(NUM_PORTS - 1)) ? '0 : id + PTR_W'(1);
  endfunction

  logic [PTR_W-1:0]            ptr;
  logic                        grant_vld;
  logic [PTR_W-1:0]            grant_id;
  logic                        sel_we;
  logic [ADDR_W-1:0]           sel_addr;
  logic [DATA_W-1:0]           sel_wdata;
  logic [DEPTH-1:0]            vld_p;
  logic [DEPTH-1:0][PTR_W-1:0] id_p;

  // ---- arbitration stage (combinational, cycle of the grant) ----
  // Round robin is done as two ordered passes over the ports: the first pass
  // accepts only ports at or above the pointer, the second takes the lowest
  // requester overall. The first hit across both passes is the next
  // requester in the p, p+1, ..., 0, ... order.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
`ifdef MEM_ARB_PRIO_EN
    if (req[0]) begin
      grant_vld = 1'b1;
      grant_id  = '0;
      sel_we    = we[0];
      sel_addr  = addr[0 +: ADDR_W];
      sel_wdata = wdata[0 +: DATA_W];
    end
`endif
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = FIRST; i < NUM_PORTS; i++) begin
        if (!grant_vld && req[i] && (pass == 1 || PTR_W'(i) >= ptr)) begin
          grant_vld = 1'b1;
          grant_id  = PTR_W'(i);
          sel_we    = we[i];
          sel_addr  = addr[i*ADDR_W +: ADDR_W];
          sel_wdata = wdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign ack = (grant_vld && !reset) ? port_onehot(grant_id) : '0;

  // ---- issue stage: memory command registers and the return tracker ----
  // vld_p/id_p track each read from the grant edge until its data arrives on
  // mem_rdata; the last slot lines up with the data and loads rvalid/rdata.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      vld_p     <= '0;
      id_p      <= '0;
      rvalid    <= '0;
      rdata     <= '0;
    end else begin
      mem_en <= grant_vld;
      if (grant_vld) begin
        mem_we    <= sel_we;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
`ifdef MEM_ARB_PRIO_EN
        if (grant_id != '0) begin
          ptr <= next_ptr(grant_id);
        end
`else
        ptr <= next_ptr(grant_id);
`endif
      end
      vld_p <= {vld_p[DEPTH-2:0], grant_vld & ~sel_we};
      id_p  <= {id_p[DEPTH-2:0], grant_id};
      // ---- return stage: capture memory data for the read now due ----
      rvalid <= vld_p[DEPTH-1] ? port_onehot(id_p[DEPTH-1]) : '0;
      if (vld_p[DEPTH-1]) begin
        rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter with NUM_PORTS=4, ADDR_W=24, DATA_W=16, MEM_LAT=3.
// A behavioural model (pointer + modulo search, return queue keyed by due
// cycle, associative memory image) is compared against every DUT output on
// every falling edge. Directed sequences add hand-computed literal checks.
// A simple memory with MEM_LAT cycles of read latency answers mem_* accesses
// and drives recognisable junk on mem_rdata when no read is due.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int NP  = 4;
  localparam int AW  = 24;
  localparam int DW  = 16;
  localparam int LAT = 3;

  logic               clock = 1'b0;
  logic               reset;
  logic [NP-1:0]      req;
  logic [NP-1:0]      we;
  logic [NP*AW-1:0]   addr;
  logic [NP*DW-1:0]   wdata;
  logic [NP-1:0]      ack;
  logic [NP-1:0]      rvalid;
  logic [DW-1:0]      rdata;
  logic               mem_en;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  mem_arbiter #(
    .NUM_PORTS (NP),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MEM_LAT   (LAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .ack       (ack),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Initial memory contents, shared by the memory and the model.
  function automatic logic [DW-1:0] preload(input logic [AW-1:0] a);
    case (a)
      24'h000010: return 16'hBEEF;
      24'h000300: return 16'h3333;
      24'h000301: return 16'h1111;
      24'h000302: return 16'h2222;
      default:    return a[15:0] ^ 16'h5A5A;
    endcase
  endfunction

  // ---------------- memory with LAT cycles of read latency ----------------
  logic [DW-1:0] bmem    [4096];
  bit            bwr     [4096];
  logic [DW-1:0] rd_pipe [LAT];

  always @(posedge clock) begin
    if (mem_en && mem_we) begin
      bmem[mem_addr[11:0]] <= mem_wdata;
      bwr[mem_addr[11:0]]  <= 1'b1;
    end
    if (mem_en && !mem_we)
      rd_pipe[0] <= bwr[mem_addr[11:0]] ? bmem[mem_addr[11:0]] : preload(mem_addr);
    else
      rd_pipe[0] <= 16'hD000 ^ 16'(cyc);
    for (int k = LAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // ---------------- behavioural model + per-cycle compare ----------------
  typedef struct {
    int            due;
    int            port;
    logic [DW-1:0] data;
  } ret_t;

  ret_t          rq[$];
  logic [DW-1:0] mmem [logic [AW-1:0]];
  int            mptr;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rd;
  logic [NP-1:0] m_rv, m_ack;

`ifdef MEM_ARB_PRIO_EN
  localparam int PTR0 = 1;
`else
  localparam int PTR0 = 0;
`endif

  function automatic int pick(input logic [NP-1:0] r, input int p);
`ifdef MEM_ARB_PRIO_EN
    if (r[0]) return 0;
    for (int k = 0; k < NP - 1; k++) begin
      int c = 1 + (p - 1 + k) % (NP - 1);
      if (r[c]) return c;
    end
`else
    for (int k = 0; k < NP; k++) begin
      int c = (p + k) % NP;
      if (r[c]) return c;
    end
`endif
    return -1;
  endfunction

  initial begin
    int g;
    forever begin
      @(negedge clock);
      if (reset) begin
        rq.delete();
        mptr    = PTR0;
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_rv    = '0;
        m_rd    = '0;
      end else begin
        m_rv = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
          m_rv[rq[0].port] = 1'b1;
          m_rd = rq[0].data;
          void'(rq.pop_front());
        end
      end
      chk("m_mem_en", mem_en, m_en);
      chk("m_mem_we", mem_we, m_we);
      chk("m_mem_addr", mem_addr, m_addr);
      chk("m_mem_wdata", mem_wdata, m_wdata);
      chk("m_rvalid", rvalid, m_rv);
      chk("m_rdata", rdata, m_rd);
      g = reset ? -1 : pick(req, mptr);
      m_ack = '0;
      if (g >= 0) m_ack[g] = 1'b1;
      chk("m_ack", ack, m_ack);
      if (!reset) begin
        m_en = (g >= 0);
        if (g >= 0) begin
          m_we    = we[g];
          m_addr  = addr[g*AW +: AW];
          m_wdata = wdata[g*DW +: DW];
          if (m_we) begin
            mmem[m_addr] = m_wdata;
          end else begin
            ret_t e;
            e.due  = cyc + LAT + 2;
            e.port = g;
            e.data = mmem.exists(m_addr) ? mmem[m_addr] : preload(m_addr);
            rq.push_back(e);
          end
`ifdef MEM_ARB_PRIO_EN
          if (g > 0) mptr = 1 + g % (NP - 1);
`else
          mptr = (g + 1) % NP;
`endif
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic look();
    @(negedge clock);
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[p*AW +: AW]  = a;
    wdata[p*DW +: DW] = d;
  endtask

  logic [NP-1:0] t2_exp [4] = '{4'b0010, 4'b0001, 4'b0010, 4'b0001};
  logic [NP-1:0] t4_rv  [6] = '{4'b0000, 4'b0000, 4'b1000, 4'b0010, 4'b0100, 4'b0000};
  logic [DW-1:0] t4_rd  [6] = '{16'hA5A5, 16'hA5A5, 16'h3333, 16'h1111, 16'h2222, 16'h2222};
  logic [NP-1:0] t5_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [NP-1:0] pr_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach its end, got cycle %0d, required completion", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    step();
    step();
    look();
    chk("rst_ack", ack, 4'b0000);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_addr", mem_addr, 24'h0);
    chk("rst_rvalid", rvalid, 4'b0000);
    chk("rst_rdata", rdata, 16'h0);
    step();
    reset = 1'b0;

`ifdef MEM_ARB_PRIO_EN
    for (int i = 0; i < NP; i++) set_port(i, AW'(32'h60 + i), '0);
    req = 4'b1111;
    repeat (3) begin
      look();
      chk("prio_port0", ack, 4'b0001);
      step();
    end
    req = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      look();
      chk("prio_rr", ack, pr_exp[i]);
      step();
    end
    req = '0;
`else
    // Single read from port 0.
    set_port(0, 24'h000010, '0);
    req = 4'b0001;
    look();
    chk("t1_ack", ack, 4'b0001);
    step();
    req = '0;
    look();
    chk("t1_mem_en", mem_en, 1'b1);
    chk("t1_mem_addr", mem_addr, 24'h000010);
    chk("t1_mem_we", mem_we, 1'b0);
    step();
    step();
    step();
    look();
    chk("t1_rvalid_early", rvalid, 4'b0000);
    step();
    look();
    chk("t1_rvalid", rvalid, 4'b0001);
    chk("t1_rdata", rdata, 16'hBEEF);
    step();

    // Ports 0 and 1 requesting continuously; pointer is at 1.
    set_port(0, 24'h000020, '0);
    set_port(1, 24'h000021, '0);
    req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      look();
      chk("t2_ack", ack, t2_exp[i]);
      step();
    end
    req = '0;
    repeat (8) step();

    // Port 1 write, then port 2 reads the same address back.
    set_port(1, 24'h000200, 16'hA5A5);
    we  = 4'b0010;
    req = 4'b0010;
    look();
    chk("t3_ack", ack, 4'b0010);
    step();
    req = '0;
    we  = '0;
    look();
    chk("t3_mem_en", mem_en, 1'b1);
    chk("t3_mem_we", mem_we, 1'b1);
    chk("t3_mem_addr", mem_addr, 24'h000200);
    chk("t3_mem_wdata", mem_wdata, 16'hA5A5);
    repeat (6) begin
      step();
      look();
      chk("t3_no_rvalid", rvalid, 4'b0000);
    end
    step();
    set_port(2, 24'h000200, '0);
    req = 4'b0100;
    look();
    chk("t3_rb_ack", ack, 4'b0100);
    step();
    req = '0;
    repeat (4) step();
    look();
    chk("t3_rb_rvalid", rvalid, 4'b0100);
    chk("t3_rb_rdata", rdata, 16'hA5A5);
    step();

    // Reads from ports 3, 1, 2 in consecutive cycles.
    set_port(3, 24'h000300, '0);
    set_port(1, 24'h000301, '0);
    set_port(2, 24'h000302, '0);
    req = 4'b1000;
    look();
    chk("t4_ack3", ack, 4'b1000);
    step();
    req = 4'b0010;
    look();
    chk("t4_ack1", ack, 4'b0010);
    step();
    req = 4'b0100;
    look();
    chk("t4_ack2", ack, 4'b0100);
    step();
    req = '0;
    for (int i = 0; i < 6; i++) begin
      look();
      chk("t4_rvalid", rvalid, t4_rv[i]);
      chk("t4_rdata", rdata, t4_rd[i]);
      step();
    end

    // Reset one cycle after a read grant.
    set_port(2, 24'h000040, '0);
    req = 4'b0100;
    look();
    chk("t5_ack", ack, 4'b0100);
    step();
    req   = 4'b0001;
    reset = 1'b1;
    look();
    chk("t5_mem_en_clr", mem_en, 1'b0);
    chk("t5_mem_addr_clr", mem_addr, 24'h0);
    chk("t5_ack_in_rst", ack, 4'b0000);
    step();
    step();
    req   = '0;
    reset = 1'b0;
    repeat (8) begin
      look();
      chk("t5_no_rvalid", rvalid, 4'b0000);
      step();
    end
    for (int i = 0; i < NP; i++) set_port(i, AW'(32'h50 + i), '0);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      look();
      chk("t5_rr", ack, t5_exp[i]);
      step();
    end
    req = '0;

    // Single requester holding req is granted every cycle.
    req = 4'b0100;
    repeat (4) begin
      look();
      chk("t6_hold", ack, 4'b0100);
      step();
    end
    req = '0;
    step();

    // Port 0 drops its request after losing to port 3.
    req = 4'b1001;
    look();
    chk("t7_ack", ack, 4'b1000);
    step();
    req = '0;
    look();
    chk("t7_mem_en", mem_en, 1'b1);
    step();
    look();
    chk("t7_no_phantom", mem_en, 1'b0);
    step();
`endif

    repeat (10) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
